axi_wr_sched: RTL

// - Write-side scheduler for the shared cache-subsystem AXI master port.
// - Round-robin arbitrates AW requests from NumReq requesters (icache, bypass, dcache) onto one AW port.
// - Records the order of granted AWs in an internal ordering queue and steers W beats from that requester until w_last.
// - Bounds outstanding write bursts. Sits between the cache requesters and the AXI request/response mux.

---
 rtl/axi_wr_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axi_wr_sched.sv
// Write-side AXI scheduler: round-robin AW arbitration across requesters,
// AW-ordered W steering, bounded number of outstanding write bursts.
module axi_wr_sched #(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned AwWidth        = 64,
  parameter int unsigned WWidth         = 73,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned PtrW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq*AwWidth-1:0] req_aw_i,
  input  logic [NumReq-1:0]         req_aw_valid_i,
  output logic [NumReq-1:0]         req_aw_ready_o,
  input  logic [NumReq*WWidth-1:0]  req_w_i,
  input  logic [NumReq-1:0]         req_w_last_i,
  input  logic [NumReq-1:0]         req_w_valid_i,
  output logic [NumReq-1:0]         req_w_ready_o,
  output logic [AwWidth-1:0]        aw_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [WWidth-1:0]         w_o,
  output logic                      w_last_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [CntW-1:0]           outstanding_o,
  output logic                      busy_o
);

  logic [IdxW-1:0] r_rr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_q [MaxOutstanding];
  logic [PtrW-1:0] r_rd;
  logic [PtrW-1:0] r_wr;
  logic [CntW-1:0] r_cnt;

  logic            w_scan_found;
  logic [IdxW-1:0] w_scan_idx;
  logic [IdxW-1:0] w_gnt_idx;
  logic            w_gnt_req;
  logic            w_full;
  logic            w_empty;
  logic [IdxW-1:0] w_head;
  logic            w_push;
  logic            w_pop;

  always_comb begin
    w_scan_found = 1'b0;
    w_scan_idx   = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      int k;
      k = (int'(r_rr) + i) % int'(NumReq);
      if (!w_scan_found && req_aw_valid_i[k]) begin
        w_scan_found = 1'b1;
        w_scan_idx   = IdxW'(k);
      end
    end
  end

  assign w_full  = (r_cnt == CntW'(MaxOutstanding));
  assign w_empty = (r_cnt == '0);

  // A locked grant keeps the AXI payload stable until the handshake
  assign w_gnt_idx = r_lock ? r_lock_idx : w_scan_idx;
  assign w_gnt_req = r_lock ? req_aw_valid_i[r_lock_idx] : w_scan_found;

  assign aw_valid_o = rst_ni & ~w_full & w_gnt_req;
  assign aw_o       = req_aw_i[int'(w_gnt_idx)*AwWidth +: AwWidth];
  assign w_push     = aw_valid_o & aw_ready_i;

  always_comb begin
    req_aw_ready_o = '0;
    if (aw_valid_o) req_aw_ready_o[w_gnt_idx] = aw_ready_i;
  end

  assign w_head    = r_q[r_rd];
  assign w_valid_o = ~w_empty & req_w_valid_i[w_head];
  assign w_last_o  = ~w_empty & req_w_last_i[w_head];
  assign w_o       = req_w_i[int'(w_head)*WWidth +: WWidth];
  assign w_pop     = w_valid_o & w_ready_i & w_last_o;

  always_comb begin
    req_w_ready_o = '0;
    if (!w_empty) req_w_ready_o[w_head] = w_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_rr   <= (w_gnt_idx == IdxW'(NumReq - 1)) ? '0
                                                   : w_gnt_idx + 1'b1;
        r_lock <= 1'b0;
        r_wr   <= (r_wr == PtrW'(MaxOutstanding - 1)) ? '0
                                                      : r_wr + 1'b1;
      end else if (aw_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_gnt_idx;
      end
      if (w_pop) begin
        r_rd <= (r_rd == PtrW'(MaxOutstanding - 1)) ? '0 : r_rd + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_wr] <= w_gnt_idx;
  end

  assign outstanding_o = r_cnt;
  assign busy_o        = (r_cnt != '0) | aw_valid_o;

  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_valid_o && !aw_ready_i |=> $stable(aw_o));
  a_aw_rdy_1h: assert property (@(posedge clk_i)
    $onehot0(req_aw_ready_o));
  a_w_rdy_1h: assert property (@(posedge clk_i)
    $onehot0(req_w_ready_o));
  a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_pop |-> !w_empty);

endmodule
